// File: rtl/fb_pkg.sv
// Shared constants and types for the framebuffer scan-out block: default
// 640x480@60 VGA geometry and the per-pixel timing control bundle.
package fb_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Sync windows as [start, end): h_cnt 656..751, v_cnt 490..491.
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam int PIXEL_COUNT  = H_ACTIVE * V_ACTIVE;

    // Timing controls that travel down the pipeline alongside the pixel.
    // hs/vs are active-low, hb/vb active-high.
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
        logic hb;
        logic vb;
    } vid_ctl_t;

    // Value of the control bundle while in reset: syncs idle, fully blanked.
    localparam vid_ctl_t CTL_IDLE = '{active: 1'b0, hs: 1'b1, vs: 1'b1, hb: 1'b1, vb: 1'b1};

endpackage

// File: rtl/fb_scanout_if.sv
// Pixel-write bus from the character renderer into the framebuffer.
// Writes are fire-and-forget: one per cycle, no back-pressure.
interface fb_scanout_if;

    logic        cpu_wr;
    logic [31:0] cpu_addr;
    logic [7:0]  cpu_data;

    modport master (output cpu_wr, cpu_addr, cpu_data);
    modport slave  (input  cpu_wr, cpu_addr, cpu_data);

endinterface

// File: rtl/fb_ram.sv
// Simple dual-port 8-bit framebuffer RAM: one write port, one registered
// read port, read-first on a same-address collision. Shaped for BRAM inference.
module fb_ram #(
    parameter int DEPTH = fb_pkg::PIXEL_COUNT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // Write and registered read share one edge; the read samples the old word.
    // NOTE: no reset on the array or read register -- a reset branch would stop BRAM inference, and reset must not clear the picture anyway.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer owner and VGA scan-out. Raster counters (S0) address the RAM,
// RAM data and delayed timing controls meet in S1, S2 registers the outputs,
// so every output for position (h,v) appears exactly two pclk after it.
module fb_scanout #(
    parameter int H_ACTIVE = fb_pkg::H_ACTIVE,
    parameter int H_FP     = fb_pkg::H_FP,
    parameter int H_SYNC   = fb_pkg::H_SYNC,
    parameter int H_BP     = fb_pkg::H_BP,
    parameter int V_ACTIVE = fb_pkg::V_ACTIVE,
    parameter int V_FP     = fb_pkg::V_FP,
    parameter int V_SYNC   = fb_pkg::V_SYNC,
    parameter int V_BP     = fb_pkg::V_BP
) (
    input  logic          pclk,
    input  logic          reset,
    fb_scanout_if.slave   cpu,
    output logic          wr_oob,
    output logic          hs,
    output logic          vs,
    output logic [7:0]    r,
    output logic [7:0]    g,
    output logic [7:0]    b,
    output logic          VGA_HB,
    output logic          VGA_VB,
    output logic          VGA_DE
);

    import fb_pkg::vid_ctl_t;
    import fb_pkg::CTL_IDLE;

    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam int PIXEL_COUNT  = H_ACTIVE * V_ACTIVE;
    localparam int HW           = $clog2(H_TOTAL);
    localparam int VW           = $clog2(V_TOTAL);
    localparam int AW           = $clog2(PIXEL_COUNT);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [AW-1:0] rd_addr;
    logic          h_last;
    logic          v_last;
    vid_ctl_t      ctl_s0;
    vid_ctl_t      ctl_s1;
    logic [7:0]    ram_q;
    logic          wr_hit;
    logic          wr_miss;

    assign h_last = (h_cnt == HW'(H_TOTAL - 1));
    assign v_last = (v_cnt == VW'(V_TOTAL - 1));

    // Raster position and linear read address; the address steps once per
    // visible pixel, which walks y*H_ACTIVE+x without a multiplier.
    // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge pclk) begin
        if (reset) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            rd_addr <= '0;
        end else begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + VW'(1);
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end

            if (h_last && v_last) begin
                rd_addr <= '0;
            end else if (ctl_s0.active) begin
                rd_addr <= rd_addr + AW'(1);
            end
        end
    end

    // S0 timing decode from the counters.
    // NOTE: the struct gets a full default first so no path through this block can infer a latch.
    always_comb begin
        ctl_s0        = CTL_IDLE;
        ctl_s0.hb     = (h_cnt >= HW'(H_ACTIVE));
        ctl_s0.vb     = (v_cnt >= VW'(V_ACTIVE));
        ctl_s0.active = !ctl_s0.hb && !ctl_s0.vb;
        ctl_s0.hs     = !((h_cnt >= HW'(H_SYNC_START)) && (h_cnt < HW'(H_SYNC_END)));
        ctl_s0.vs     = !((v_cnt >= VW'(V_SYNC_START)) && (v_cnt < VW'(V_SYNC_END)));
    end

    // Writes are not gated by reset: the renderer may keep drawing through it.
    assign wr_hit  = cpu.cpu_wr && (cpu.cpu_addr <  32'(PIXEL_COUNT));
    assign wr_miss = cpu.cpu_wr && (cpu.cpu_addr >= 32'(PIXEL_COUNT));

    // Sticky record of any dropped out-of-range write.
    always_ff @(posedge pclk) begin
        if (reset) begin
            wr_oob <= 1'b0;
        end else if (wr_miss) begin
            wr_oob <= 1'b1;
        end
    end

    fb_ram #(
        .DEPTH (PIXEL_COUNT),
        .AW    (AW)
    ) u_ram (
        .clk   (pclk),
        .we    (wr_hit),
        .waddr (cpu.cpu_addr[AW-1:0]),
        .wdata (cpu.cpu_data),
        .raddr (rd_addr),
        .rdata (ram_q)
    );

    // S1: delay the controls by one cycle to line up with the RAM read data.
    always_ff @(posedge pclk) begin
        if (reset) begin
            ctl_s1 <= CTL_IDLE;
        end else begin
            ctl_s1 <= ctl_s0;
        end
    end

    // S2: registered video outputs; grey level drives all three channels.
    always_ff @(posedge pclk) begin
        if (reset) begin
            hs     <= 1'b1;
            vs     <= 1'b1;
            VGA_HB <= 1'b1;
            VGA_VB <= 1'b1;
            VGA_DE <= 1'b0;
            r      <= 8'h00;
            g      <= 8'h00;
            b      <= 8'h00;
        end else begin
            hs     <= ctl_s1.hs;
            vs     <= ctl_s1.vs;
            VGA_HB <= ctl_s1.hb;
            VGA_VB <= ctl_s1.vb;
            VGA_DE <= ctl_s1.active;
            r      <= ctl_s1.active ? ram_q : 8'h00;
            g      <= ctl_s1.active ? ram_q : 8'h00;
            b      <= ctl_s1.active ? ram_q : 8'h00;
        end
    end

endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout on a reduced raster so several whole
// frames fit in a short run. Each cycle the expected outputs for the current
// raster position are pushed; they are popped two cycles later and compared.
module tb_fb_scanout;

    localparam int H_ACTIVE    = 20;
    localparam int H_FP        = 2;
    localparam int H_SYNC      = 5;
    localparam int H_BP        = 3;
    localparam int V_ACTIVE    = 6;
    localparam int V_FP        = 1;
    localparam int V_SYNC      = 2;
    localparam int V_BP        = 2;
    localparam int H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME       = H_TOTAL * V_TOTAL;
    localparam int PIXEL_COUNT = H_ACTIVE * V_ACTIVE;
    localparam int HSS         = H_ACTIVE + H_FP;
    localparam int HSE         = HSS + H_SYNC;
    localparam int VSS         = V_ACTIVE + V_FP;
    localparam int VSE         = VSS + V_SYNC;

    logic       pclk = 1'b0;
    logic       reset;
    logic       wr_oob;
    logic       hs;
    logic       vs;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       VGA_HB;
    logic       VGA_VB;
    logic       VGA_DE;

    fb_scanout_if bus ();

    fb_scanout #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) dut (
        .pclk   (pclk),
        .reset  (reset),
        .cpu    (bus),
        .wr_oob (wr_oob),
        .hs     (hs),
        .vs     (vs),
        .r      (r),
        .g      (g),
        .b      (b),
        .VGA_HB (VGA_HB),
        .VGA_VB (VGA_VB),
        .VGA_DE (VGA_DE)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        bit       hs;
        bit       vs;
        bit       hb;
        bit       vb;
        bit       de;
        bit [7:0] pix;
        bit       known;
        int       h;
        int       v;
    } exp_t;

    exp_t     sb[$];
    bit [7:0] mem_m   [PIXEL_COUNT];
    bit       known_m [PIXEL_COUNT];
    int       h_m      = 0;
    int       v_m      = 0;
    bit       rst_prev = 1'b1;
    bit       oob_m    = 1'b0;
    int       total    = 0;
    int       bad      = 0;
    int       cyc      = 0;

    // Waveform measurements, independent of the scoreboard.
    bit hs_prev, vs_prev, de_prev;
    int hs_fall, vs_fall, de_run, de_lines;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t reset_entry();
        exp_t e;
        e.hs = 1'b1; e.vs = 1'b1; e.hb = 1'b1; e.vb = 1'b1; e.de = 1'b0;
        e.pix = 8'h00; e.known = 1'b1; e.h = -1; e.v = -1;
        return e;
    endfunction

    // Expected outputs for raster position (h,v), pixel taken from the model
    // memory as it stands before this cycle's write (read-first).
    function automatic exp_t expect_at(int h, int v);
        exp_t e;
        e.h  = h;
        e.v  = v;
        e.hb = (h >= H_ACTIVE);
        e.vb = (v >= V_ACTIVE);
        e.de = !e.hb && !e.vb;
        e.hs = !(h >= HSS && h < HSE);
        e.vs = !(v >= VSS && v < VSE);
        if (e.de) begin
            e.pix   = mem_m[v * H_ACTIVE + h];
            e.known = known_m[v * H_ACTIVE + h];
        end else begin
            e.pix   = 8'h00;
            e.known = 1'b1;
        end
        return e;
    endfunction

    task automatic measure();
        if (hs_prev && !hs) begin
            if (hs_fall >= 0) check("hs_period", 32'(cyc - hs_fall), 32'(H_TOTAL));
            hs_fall = cyc;
        end
        if (!hs_prev && hs && hs_fall >= 0) check("hs_low", 32'(cyc - hs_fall), 32'(H_SYNC));
        hs_prev = hs;

        if (vs_prev && !vs) begin
            if (vs_fall >= 0) check("vs_period", 32'(cyc - vs_fall), 32'(FRAME));
            vs_fall = cyc;
            check("de_lines", 32'(de_lines), 32'(V_ACTIVE));
            de_lines = 0;
        end
        if (!vs_prev && vs && vs_fall >= 0) check("vs_low", 32'(cyc - vs_fall), 32'(V_SYNC * H_TOTAL));
        vs_prev = vs;

        if (VGA_DE) begin
            de_run++;
        end else if (de_prev) begin
            check("de_len", 32'(de_run), 32'(H_ACTIVE));
            de_lines++;
            de_run = 0;
        end
        de_prev = VGA_DE;
    endtask

    // One pclk: compare outputs due now, then drive this cycle's inputs and
    // advance the reference model.
    task automatic step(input bit rst, input bit wr, input logic [31:0] addr, input logic [7:0] data);
        exp_t  e;
        string at;
        @(negedge pclk);
        cyc++;
        if (rst_prev) begin
            sb.delete();
            sb.push_back(reset_entry());
            sb.push_back(reset_entry());
            h_m = 0;
            v_m = 0;
            hs_prev = 1'b1; vs_prev = 1'b1; de_prev = 1'b0;
            hs_fall = -1;   vs_fall = -1;   de_run = 0; de_lines = 0;
        end
        sb.push_back(expect_at(h_m, v_m));
        e  = sb.pop_front();
        at = $sformatf("@(%0d,%0d)", e.h, e.v);
        check({"hs", at},     32'(hs),     32'(e.hs));
        check({"vs", at},     32'(vs),     32'(e.vs));
        check({"hb", at},     32'(VGA_HB), 32'(e.hb));
        check({"vb", at},     32'(VGA_VB), 32'(e.vb));
        check({"de", at},     32'(VGA_DE), 32'(e.de));
        if (e.known) begin
            check({"r", at}, 32'(r), 32'(e.pix));
            check({"g", at}, 32'(g), 32'(e.pix));
            check({"b", at}, 32'(b), 32'(e.pix));
        end
        check({"wr_oob", at}, 32'(wr_oob), 32'(oob_m));
        measure();

        bus.cpu_wr   = wr;
        bus.cpu_addr = addr;
        bus.cpu_data = data;
        reset        = rst;

        if (wr && addr < 32'(PIXEL_COUNT)) begin
            mem_m[int'(addr)]   = data;
            known_m[int'(addr)] = 1'b1;
        end
        oob_m    = rst ? 1'b0 : (oob_m | (wr && addr >= 32'(PIXEL_COUNT)));
        rst_prev = rst;
        if (!rst) begin
            if (h_m == H_TOTAL - 1) begin
                h_m = 0;
                v_m = (v_m == V_TOTAL - 1) ? 0 : v_m + 1;
            end else begin
                h_m++;
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: run did not complete, cycles=%0d required<%0d", cyc, 300000 / 10);
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        bus.cpu_wr   = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_data = '0;

        // Three reset cycles: outputs must sit at their reset values.
        repeat (3) step(1'b1, 1'b0, 32'd0, 8'h00);

        // Frame A: clear every pixel to 0x00.
        for (int i = 0; i < FRAME; i++) begin
            if (i < PIXEL_COUNT) step(1'b0, 1'b1, 32'(i), 8'h00);
            else                 step(1'b0, 1'b0, 32'd0, 8'h00);
        end

        // Frame B: collision at addr 100 while it is being read, corner and
        // line-edge pixels, then two out-of-range writes.
        for (int i = 0; i < FRAME; i++) begin
            case (i)
                100 / H_ACTIVE * H_TOTAL + 100 % H_ACTIVE:
                         step(1'b0, 1'b1, 32'd100, 8'h55);
                200:     step(1'b0, 1'b1, 32'd0, 8'hFF);
                201:     step(1'b0, 1'b1, 32'(H_ACTIVE - 1), 8'h80);
                202:     step(1'b0, 1'b1, 32'(H_ACTIVE), 8'h40);
                203:     step(1'b0, 1'b1, 32'(PIXEL_COUNT - 1), 8'h11);
                204:     step(1'b0, 1'b1, 32'(PIXEL_COUNT), 8'hAA);
                205:     step(1'b0, 1'b1, 32'hFFFF_FFFF, 8'hAA);
                default: step(1'b0, 1'b0, 32'd0, 8'h00);
            endcase
        end

        // Frame C: idle, shows everything written during frame B.
        repeat (FRAME) step(1'b0, 1'b0, 32'd0, 8'h00);

        // Frame D: reset in mid-frame at (10,3), with a write in the reset cycle.
        for (int k = 0; k < FRAME && !(h_m == 10 && v_m == 3); k++) begin
            step(1'b0, 1'b0, 32'd0, 8'h00);
        end
        check("pos_before_reset", 32'(h_m * 1000 + v_m), 32'(10 * 1000 + 3));
        step(1'b1, 1'b1, 32'd5, 8'h77);

        // Two clean frames after the restart, plus pipeline flush.
        repeat (2 * FRAME + 3) step(1'b0, 1'b0, 32'd0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
